ll_sc_unit: RTL and testbench
=============================

// Module: ll_sc_unit
// PURPOSE
//  MEM-stage atomic-access controller for MIPS LL/SC; sits directly upstream of the LLbit register.
//  - Performs the LL read and the conditional SC write over a req/ack data bus.
//  - Keeps the linked word address.
//  - Produces the LLbit write (llbit_we/llbit_wdata) and the GPR result (loaded word, or SC 1/0).
//  - Stalls the pipeline while a bus access is outstanding.
// PARAMETERS
//  DATA_W      32   data bus / result width
//  ADDR_W      32   byte address width
//  TIMEOUT     255  max cycles waiting for mem_ack before bus_err (8-bit counter)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       synchronous reset, active-high
//  flush        in   1       exception/ERET flush; aborts current operation
//  in_valid     in   1       MEM-stage instruction valid
//  in_op        in   2       00 none, 01 LL, 10 SC, 11 reserved (treated as none)
//  in_addr      in   ADDR_W  effective byte address
//  in_wdata     in   DATA_W  SC store data (rt)
//  llbit_q      in   1       current LLbit register value
//  mem_req      out  1       bus request
//  mem_we       out  1       1 = write (SC), 0 = read (LL)
//  mem_addr     out  ADDR_W  word-aligned bus address
//  mem_wdata    out  DATA_W  write data
//  mem_ack      in   1       bus completion, 1-cycle pulse
//  mem_rdata    in   DATA_W  read data, valid with mem_ack
//  stall        out  1       hold upstream pipeline
//  result_valid out  1       1-cycle pulse: result_data ready for writeback
//  result_data  out  DATA_W  LL word, or SC status (1 success, 0 fail)
//  llbit_we     out  1       LLbit write enable
//  llbit_wdata  out  1       LLbit write value
//  addr_err     out  1       1-cycle pulse: misaligned (addr[1:0]!=0) LL/SC
//  bus_err      out  1       1-cycle pulse: TIMEOUT expired
// BEHAVIOUR
//  Reset values: all outputs 0; link_valid=0; link_addr=0; state=IDLE; timeout counter=0.
//  FSM states: IDLE, RD_WAIT, WR_WAIT, RESP.
//  IDLE (flush=0, in_valid=1):
//   - LL, misaligned: addr_err=1 next cycle; no bus access; stay IDLE.
//   - LL, aligned: -> RD_WAIT; latch addr.
//   - SC, misaligned: addr_err=1 next cycle; no bus access; stay IDLE.
//   - SC, aligned, llbit_q=1 & link_valid & in_addr[ADDR_W-1:2]==link_addr: -> WR_WAIT; latch addr/data.
//   - SC, aligned, otherwise: -> RESP with result_data=0; no bus access; LLbit untouched.
//  RD_WAIT/WR_WAIT: mem_req=1, mem_we=(WR_WAIT); addr/wdata held stable until ack.
//   - Counter increments each waiting cycle; cleared on entry.
//  Ack in RD_WAIT: -> RESP; result_data=mem_rdata; llbit_we=1, llbit_wdata=1 (same cycle as ack);
//   link_addr<=addr[ADDR_W-1:2]; link_valid<=1.
//  Ack in WR_WAIT: -> RESP; result_data=1; llbit_we=1, llbit_wdata=0; link_valid<=0.
//  Counter reaches TIMEOUT without ack: bus_err pulse; -> IDLE; no result; LLbit untouched.
//  RESP: result_valid=1 for exactly one cycle; -> IDLE.
//  stall = (IDLE & in_valid & op in {LL,SC} & aligned & !flush) | RD_WAIT | WR_WAIT.
//   - stall=0 in RESP.
//  Latency: LL/SC with ack N cycles after request -> result_valid N+1 cycles after request.
//   - SC fail: result_valid 1 cycle after issue.
//  flush (highest priority after rst): any state -> IDLE next cycle.
//   - mem_req drops next cycle; an ack coinciding with flush is ignored.
//   - Ignored ack: no result, no llbit_we.
//   - link_valid<=0; llbit_we not driven (LLbit reg clears itself on flush).
//  rst mid-operation: immediate return to reset values on the clock edge; bus request abandoned.
//  Simultaneous llbit_we and flush cannot occur (flush suppresses all writes).
// TESTING
//  1. LL 0x100, ack after 3 cyc, rdata 0xDEADBEEF
//     -> stall 4 cyc; result 0xDEADBEEF; llbit_we=1/wdata=1; link=0x100.
//  2. LL 0x100 then SC 0x100 data 0x5 with llbit_q=1
//     -> mem write 0x100/0x5; result_data=1; llbit_we wdata=0.
//  3. SC 0x104 after LL 0x100 (llbit_q=1)
//     -> no mem_req; result_data=0 one cycle later; llbit_we=0.
//  4. LL 0x102 -> addr_err pulse; mem_req never asserted; stall=0.
//  5. LL 0x200, flush asserted on same cycle as mem_ack
//     -> no result_valid, no llbit_we; following SC 0x200 fails.
//  6. LL 0x300, no ack -> bus_err after TIMEOUT=255 waiting cycles; state IDLE; stall released.

Source files
------------

// File: rtl/ll_sc_unit.sv
// ll_sc_unit: MEM-stage LL/SC atomic-access controller.
// Performs the LL read and the conditional SC write over a req/ack bus.
// It keeps the linked word address, drives the LLbit register update and
// returns the GPR result. The upstream pipeline is stalled while a bus access
// is in flight.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | no access outstanding; decodes the MEM-stage instruction
// S_RD_WAIT  | LL read issued; waiting for mem_ack
// S_WR_WAIT  | SC write issued (link still valid); waiting for mem_ack
// S_RESP     | one-cycle result_valid pulse for writeback
module ll_sc_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [1:0]        in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic              llbit_q,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              result_valid,
    output logic [DATA_W-1:0] result_data,
    output logic              llbit_we,
    output logic              llbit_wdata,
    output logic              addr_err,
    output logic              bus_err
);

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_WR_WAIT = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-3:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   result_q;
    logic [ADDR_W-3:0]   link_addr;
    logic                link_valid;
    logic [CNT_W-1:0]    cnt_q;
    logic                addr_err_q;
    logic                bus_err_q;

    logic is_ll, is_sc, aligned, link_hit, busy, timeout_hit;

    // Instruction decode and status terms shared by all processes
    always_comb begin
        is_ll       = in_valid && (in_op == 2'b01);
        is_sc       = in_valid && (in_op == 2'b10);
        aligned     = (in_addr[1:0] == 2'b00);
        link_hit    = llbit_q && link_valid && (in_addr[ADDR_W-1:2] == link_addr);
        busy        = (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT);
        timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; flush overrides everything except reset
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_ll && aligned)      state_d = S_RD_WAIT;
                    else if (is_sc && aligned) state_d = link_hit ? S_WR_WAIT : S_RESP;
                end
                S_RD_WAIT, S_WR_WAIT: begin
                    if (mem_ack)          state_d = S_RESP;
                    else if (timeout_hit) state_d = S_IDLE;
                end
                S_RESP:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath: latched request, link tracking, result, wait counter, error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            result_q   <= '0;
            link_addr  <= '0;
            link_valid <= 1'b0;
            cnt_q      <= '0;
            addr_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            addr_err_q <= !flush && (state_q == S_IDLE) && (is_ll || is_sc) && !aligned;
            bus_err_q  <= !flush && busy && !mem_ack && timeout_hit;

            // Zero on the first waiting cycle, then counts each cycle without ack
            if (flush || !busy) cnt_q <= '0;
            else                cnt_q <= cnt_q + 1'b1;

            if (flush) begin
                link_valid <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (is_ll && aligned) begin
                            addr_q <= in_addr[ADDR_W-1:2];
                        end else if (is_sc && aligned) begin
                            if (link_hit) begin
                                addr_q  <= in_addr[ADDR_W-1:2];
                                wdata_q <= in_wdata;
                            end else begin
                                result_q <= '0;
                            end
                        end
                    end
                    S_RD_WAIT: begin
                        if (mem_ack) begin
                            result_q   <= mem_rdata;
                            link_addr  <= addr_q;
                            link_valid <= 1'b1;
                        end
                    end
                    S_WR_WAIT: begin
                        if (mem_ack) begin
                            result_q   <= DATA_W'(1);
                            link_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Outputs; bus address/data are forced to zero when no access is outstanding
    always_comb begin
        mem_req      = busy;
        mem_we       = (state_q == S_WR_WAIT);
        mem_addr     = busy ? {addr_q, 2'b00} : '0;
        mem_wdata    = (state_q == S_WR_WAIT) ? wdata_q : '0;
        stall        = ((state_q == S_IDLE) && (is_ll || is_sc) && aligned && !flush) || busy;
        result_valid = (state_q == S_RESP) && !flush;
        result_data  = result_q;
        llbit_we     = busy && mem_ack && !flush;
        llbit_wdata  = (state_q == S_RD_WAIT) && mem_ack && !flush;
        addr_err     = addr_err_q;
        bus_err      = bus_err_q;
    end

endmodule

// File: tb/tb_ll_sc_unit.sv
// Directed testbench for ll_sc_unit: LL, SC success/fail, misalignment,
// flush against ack, bus timeout and reset mid-operation.
module tb_ll_sc_unit;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, llbit_q, mem_ack;
    logic [1:0]  in_op;
    logic [31:0] in_addr, in_wdata, mem_rdata;
    logic        mem_req, mem_we, stall, result_valid, llbit_we, llbit_wdata, addr_err, bus_err;
    logic [31:0] mem_addr, mem_wdata, result_data;

    int checks = 0;
    int passed = 0;

    ll_sc_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_op(in_op),
        .in_addr(in_addr), .in_wdata(in_wdata), .llbit_q(llbit_q),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
        .result_valid(result_valid), .result_data(result_data),
        .llbit_we(llbit_we), .llbit_wdata(llbit_wdata),
        .addr_err(addr_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Present an instruction for one cycle starting at a falling edge
    task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wd;
    endtask

    // Completes an LL with a one-cycle ack; used to set up the link
    task automatic do_ll(input logic [31:0] addr, input logic [31:0] rd);
        issue(2'b01, addr, 32'h0);
        @(negedge clk);
        in_valid = 1'b0; mem_ack = 1'b1; mem_rdata = rd;
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 0; in_valid = 0; in_op = 0; in_addr = 0; in_wdata = 0;
        llbit_q = 0; mem_ack = 0; mem_rdata = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, stall, result_valid, llbit_we, llbit_wdata, addr_err, bus_err} !== 8'h00
            || mem_addr !== 0 || mem_wdata !== 0 || result_data !== 0)
            $display("FAIL reset_outputs: ctl=%b addr=%h wd=%h res=%h required all zero",
                     {mem_req, mem_we, stall, result_valid, llbit_we, llbit_wdata, addr_err, bus_err},
                     mem_addr, mem_wdata, result_data);
        else passed++;
    endtask

    task automatic test_ll();
        int stall_cnt = 0;
        issue(2'b01, 32'h100, 32'h0);
        #1 if (stall) stall_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
        if (stall) stall_cnt++;
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100)
            $display("FAIL ll_bus_read: req=%b we=%b addr=%h required 1 0 00000100", mem_req, mem_we, mem_addr);
        else passed++;
        @(negedge clk);
        if (stall) stall_cnt++;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1 if (stall) stall_cnt++;
        checks++;
        if (llbit_we !== 1'b1 || llbit_wdata !== 1'b1)
            $display("FAIL ll_llbit_write: we=%b wdata=%b required 1 1", llbit_we, llbit_wdata);
        else passed++;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if (result_valid !== 1'b1 || result_data !== 32'hDEADBEEF || stall !== 1'b0 || mem_req !== 1'b0)
            $display("FAIL ll_result: valid=%b data=%h stall=%b req=%b required 1 deadbeef 0 0",
                     result_valid, result_data, stall, mem_req);
        else passed++;
        checks++;
        if (stall_cnt !== 4) $display("FAIL ll_stall_cycles: got %0d required 4", stall_cnt);
        else passed++;
        @(negedge clk);
        checks++;
        if (result_valid !== 1'b0) $display("FAIL ll_result_pulse: valid=%b required 0", result_valid);
        else passed++;
    endtask

    task automatic test_sc_success();
        llbit_q = 1'b1;
        issue(2'b10, 32'h100, 32'h5);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'h5)
            $display("FAIL sc_bus_write: req=%b we=%b addr=%h wd=%h required 1 1 00000100 00000005",
                     mem_req, mem_we, mem_addr, mem_wdata);
        else passed++;
        mem_ack = 1'b1;
        #1 checks++;
        if (llbit_we !== 1'b1 || llbit_wdata !== 1'b0)
            $display("FAIL sc_llbit_clear: we=%b wdata=%b required 1 0", llbit_we, llbit_wdata);
        else passed++;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if (result_valid !== 1'b1 || result_data !== 32'h1)
            $display("FAIL sc_success_result: valid=%b data=%h required 1 00000001", result_valid, result_data);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_sc_fail_addr();
        do_ll(32'h100, 32'h12345678);
        @(negedge clk);
        llbit_q = 1'b1;
        issue(2'b10, 32'h104, 32'h7);
        #1 checks++;
        if (stall !== 1'b1 || llbit_we !== 1'b0)
            $display("FAIL sc_fail_issue: stall=%b llbit_we=%b required 1 0", stall, llbit_we);
        else passed++;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (result_valid !== 1'b1 || result_data !== 32'h0 || mem_req !== 1'b0 || llbit_we !== 1'b0)
            $display("FAIL sc_fail_result: valid=%b data=%h req=%b llbit_we=%b required 1 00000000 0 0",
                     result_valid, result_data, mem_req, llbit_we);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_misaligned();
        issue(2'b01, 32'h102, 32'h0);
        #1 checks++;
        if (stall !== 1'b0) $display("FAIL misalign_stall: stall=%b required 0", stall);
        else passed++;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (addr_err !== 1'b1 || mem_req !== 1'b0)
            $display("FAIL misalign_addr_err: addr_err=%b req=%b required 1 0", addr_err, mem_req);
        else passed++;
        @(negedge clk);
        checks++;
        if (addr_err !== 1'b0 || mem_req !== 1'b0 || result_valid !== 1'b0)
            $display("FAIL misalign_after: addr_err=%b req=%b valid=%b required 0 0 0",
                     addr_err, mem_req, result_valid);
        else passed++;
    endtask

    task automatic test_flush_ack();
        issue(2'b01, 32'h200, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h200)
            $display("FAIL flush_req: req=%b addr=%h required 1 00000200", mem_req, mem_addr);
        else passed++;
        mem_ack = 1'b1; flush = 1'b1; mem_rdata = 32'hCAFEF00D;
        #1 checks++;
        if (llbit_we !== 1'b0) $display("FAIL flush_llbit_we: llbit_we=%b required 0", llbit_we);
        else passed++;
        @(negedge clk);
        mem_ack = 1'b0; flush = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || mem_req !== 1'b0 || stall !== 1'b0)
            $display("FAIL flush_abort: valid=%b req=%b stall=%b required 0 0 0", result_valid, mem_req, stall);
        else passed++;
        llbit_q = 1'b1;
        issue(2'b10, 32'h200, 32'h9);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (result_valid !== 1'b1 || result_data !== 32'h0 || mem_req !== 1'b0)
            $display("FAIL flush_sc_fails: valid=%b data=%h req=%b required 1 00000000 0",
                     result_valid, result_data, mem_req);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int req_cnt = 0;
        int rv_cnt = 0;
        bit seen = 0;
        issue(2'b01, 32'h300, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (bus_err) seen = 1;
            else begin
                if (mem_req) req_cnt++;
                if (result_valid) rv_cnt++;
                @(negedge clk);
            end
        end
        checks++;
        if (!seen) $display("FAIL timeout_bus_err: bus_err not seen within 300 cycles");
        else passed++;
        checks++;
        if (req_cnt !== 255 || rv_cnt !== 0)
            $display("FAIL timeout_wait_cycles: req=%0d results=%0d required 255 0", req_cnt, rv_cnt);
        else passed++;
        checks++;
        if (stall !== 1'b0 || mem_req !== 1'b0 || llbit_we !== 1'b0)
            $display("FAIL timeout_release: stall=%b req=%b llbit_we=%b required 0 0 0", stall, mem_req, llbit_we);
        else passed++;
        @(negedge clk);
        checks++;
        if (bus_err !== 1'b0) $display("FAIL timeout_pulse: bus_err=%b required 0", bus_err);
        else passed++;
    endtask

    task automatic test_reset_mid_op();
        do_ll(32'h400, 32'h1);
        @(negedge clk);
        issue(2'b01, 32'h500, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || stall !== 1'b0 || result_data !== 32'h0)
            $display("FAIL rst_mid_op: req=%b stall=%b data=%h required 0 0 00000000", mem_req, stall, result_data);
        else passed++;
        llbit_q = 1'b1;
        issue(2'b10, 32'h400, 32'h3);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || result_valid !== 1'b1 || result_data !== 32'h0)
            $display("FAIL rst_clears_link: req=%b valid=%b data=%h required 0 1 00000000",
                     mem_req, result_valid, result_data);
        else passed++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_ll();
        test_sc_success();
        test_sc_fail_addr();
        test_misaligned();
        test_flush_ack();
        test_timeout();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
